// File: rtl/wb_partition_bridge.sv
// Wishbone fan-out bridge: one transaction at a time to a decoded partition, with timeout, local IRQ mask/status and IRQ merge.
// Optional monitor port la_data_out is enabled by defining WB_BRIDGE_LA_MON_EN.
//   state | meaning
//   IDLE  | waiting for an upstream request; ack from a previous response still high blocks a new one
//   BUSY  | partition cycle open, watchdog counting
//   RESP  | response captured; wbs_ack_o is registered from this state
module wb_partition_bridge #(
    parameter int          NB_PART  = 2,
    parameter int          SEL_MSB  = 23,
    parameter int          SEL_LSB  = 20,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NB_PART-1:0]      m_cyc_o,
    output logic [NB_PART-1:0]      m_stb_o,
    output logic                    m_we_o,
    output logic [3:0]              m_sel_o,
    output logic [31:0]             m_adr_o,
    output logic [31:0]             m_dat_o,
    input  logic [NB_PART-1:0]      m_ack_i,
    input  logic [32*NB_PART-1:0]   m_dat_i,
    input  logic [3*NB_PART-1:0]    part_irq_i,
    output logic [2:0]              user_irq
`ifdef WB_BRIDGE_LA_MON_EN
    ,
    output logic [127:0]            la_data_out
`endif
);

    localparam int             SW        = SEL_MSB - SEL_LSB + 1;
    localparam int             MW        = 3 * NB_PART;
    localparam logic [SW-1:0]  SEL_LOCAL = '1;
    localparam logic [SW-1:0]  SEL_NB    = SW'(NB_PART);
    localparam logic [15:0]    TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [7:0]     NB_FIELD  = 8'(NB_PART);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t             state, state_nxt;
    logic               req_we;
    logic [3:0]         req_sel;
    logic [31:0]        req_adr, req_dat, resp_data;
    logic [SW-1:0]      req_part;
    logic [15:0]        counter;
    logic [MW-1:0]      irq_mask, mask_wr;
    logic               to_flag;
    logic [3:0]         to_part;
    logic [NB_PART-1:0] part_cyc;

    logic               req_valid, is_part, is_local, ack_hit, timeout_hit;
    logic [SW-1:0]      sel_field;
    logic [31:0]        part_rdata, local_rdata;

    assign sel_field   = wbs_adr_i[SEL_MSB:SEL_LSB];
    assign req_valid   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign is_part     = sel_field < SEL_NB;
    assign is_local    = sel_field == SEL_LOCAL;
    // part_cyc is one-hot on the selected partition, so other acks are masked out here
    assign ack_hit     = |(m_ack_i & part_cyc);
    assign timeout_hit = counter == TO_LAST;

    always_comb begin
        part_rdata = '0;
        for (int p = 0; p < NB_PART; p++)
            if (part_cyc[p]) part_rdata = m_dat_i[32*p +: 32];
    end

    always_comb begin
        for (int i = 0; i < MW; i++)
            mask_wr[i] = wbs_sel_i[i/8] ? wbs_dat_i[i] : irq_mask[i];
    end

    always_comb begin
        case (wbs_adr_i[3:2])
            2'd0:    local_rdata = 32'(irq_mask);
            2'd1:    local_rdata = {16'h0, NB_FIELD, to_part, 3'b000, to_flag};
            default: local_rdata = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = is_part ? BUSY : RESP;
            BUSY: begin
                if (!wbs_cyc_i)                 state_nxt = IDLE;
                else if (ack_hit || timeout_hit) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_sel   <= '0;
            req_adr   <= '0;
            req_dat   <= '0;
            req_part  <= '0;
            resp_data <= '0;
            counter   <= '0;
            irq_mask  <= '1;
            to_flag   <= 1'b0;
            to_part   <= '0;
            part_cyc  <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state     <= state_nxt;
            wbs_ack_o <= (state == RESP);
            wbs_dat_o <= (state == RESP) ? resp_data : '0;
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (req_valid) begin
                        req_we   <= wbs_we_i;
                        req_sel  <= wbs_sel_i;
                        req_adr  <= wbs_adr_i;
                        req_dat  <= wbs_dat_i;
                        req_part <= sel_field;
                        if (is_part) begin
                            part_cyc <= NB_PART'(1) << sel_field;
                        end else if (is_local) begin
                            resp_data <= wbs_we_i ? '0 : local_rdata;
                            if (wbs_we_i && wbs_adr_i[3:2] == 2'd0)
                                irq_mask <= mask_wr;
                            if (wbs_we_i && wbs_adr_i[3:2] == 2'd1 && wbs_sel_i[0] && wbs_dat_i[0])
                                to_flag <= 1'b0;
                        end else begin
                            resp_data <= ERR_DATA;
                        end
                    end
                end
                BUSY: begin
                    counter <= counter + 16'd1;
                    if (!wbs_cyc_i) begin
                        part_cyc <= '0;
                    end else if (ack_hit) begin
                        part_cyc  <= '0;
                        resp_data <= part_rdata;
                    end else if (timeout_hit) begin
                        part_cyc  <= '0;
                        resp_data <= ERR_DATA;
                        to_flag   <= 1'b1;
                        to_part   <= 4'(req_part);
                    end
                end
                default: counter <= '0;
            endcase
        end
    end

    assign m_cyc_o = part_cyc;
    assign m_stb_o = part_cyc;
    assign m_we_o  = req_we;
    assign m_sel_o = req_sel;
    assign m_adr_o = req_adr;
    assign m_dat_o = req_dat;

    always_comb begin
        user_irq = '0;
        for (int p = 0; p < NB_PART; p++)
            for (int k = 0; k < 3; k++)
                user_irq[k] = user_irq[k] | (part_irq_i[3*p+k] & irq_mask[3*p+k]);
    end

`ifdef WB_BRIDGE_LA_MON_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) la_data_out <= '0;
        else          la_data_out <= {45'h0, to_flag, counter, state, resp_data, req_adr};
    end
`endif

endmodule

// File: tb/tb_wb_partition_bridge.sv
// Directed bench for wb_partition_bridge (NB_PART=2, TIMEOUT=8) with a per-cycle expectation model.
module tb_wb_partition_bridge;
    localparam int          NB  = 2;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cyc, stb, we;
    logic [3:0]  bsel;
    logic [31:0] adr, dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [NB-1:0] m_cyc_o, m_stb_o, m_ack;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [32*NB-1:0] m_dat;
    logic [3*NB-1:0]  part_irq;
    logic [2:0]  user_irq;

    wb_partition_bridge #(.NB_PART(NB), .SEL_MSB(23), .SEL_LSB(20), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(bsel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack), .m_dat_i(m_dat),
        .part_irq_i(part_irq), .user_irq(user_irq)
    );

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    // expectation model
    logic          exp_ack, exp_we;
    logic [31:0]   exp_dat, exp_adr, exp_wdat;
    logic [NB-1:0] exp_mcyc;
    logic [5:0]    mask_m;
    logic          to_flag_m;
    logic [3:0]    to_part_m;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endfunction

    function automatic logic [2:0] irq_model();
        logic [2:0] r = 3'b000;
        for (int p = 0; p < NB; p++)
            for (int k = 0; k < 3; k++)
                if (part_irq[3*p+k] && mask_m[3*p+k]) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] local_expect(input logic [31:0] a, input logic w);
        if (a[23:20] != 4'hF) return ERR;
        if (w) return 32'h0;
        case (a[3:2])
            2'd0:    return {26'h0, mask_m};
            2'd1:    return {16'h0, 8'(NB), to_part_m, 3'b000, to_flag_m};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wbs_ack", 32'(wbs_ack_o), 32'(exp_ack));
            chk("wbs_dat", wbs_dat_o, exp_dat);
            chk("m_cyc", 32'(m_cyc_o), 32'(exp_mcyc));
            chk("m_stb", 32'(m_stb_o), 32'(exp_mcyc));
            if (exp_mcyc != '0) begin
                chk("m_adr", m_adr_o, exp_adr);
                chk("m_dat", m_dat_o, exp_wdat);
                chk("m_we", 32'(m_we_o), 32'(exp_we));
            end
            chk("user_irq", 32'(user_irq), 32'(irq_model()));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; bsel = s;
    endtask

    task automatic end_req();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic local_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] got);
        logic [31:0] rd;
        rd = local_expect(a, w);
        start_req(a, w, d, s);
        tick();
        if (w && a[23:20] == 4'hF) begin
            if (a[3:2] == 2'd0 && s[0]) mask_m = d[5:0];
            if (a[3:2] == 2'd1 && s[0] && d[0]) to_flag_m = 1'b0;
        end
        tick();
        exp_ack = 1'b1; exp_dat = rd; got = wbs_dat_o;
        end_req();
        tick();
        exp_ack = 1'b0; exp_dat = '0;
    endtask

    // delay < 0: partition never acks
    task automatic part_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input int delay, input logic [31:0] rd, output logic [31:0] got);
        int p;
        p = int'(a[23:20]);
        start_req(a, w, d, 4'hF);
        tick();
        exp_mcyc = NB'(1) << p; exp_adr = a; exp_wdat = d; exp_we = w;
        if (delay >= 0) begin
            repeat (delay) tick();
            m_ack[p] = 1'b1; m_dat[32*p +: 32] = rd;
            tick();
            m_ack[p] = 1'b0; exp_mcyc = '0;
        end else begin
            repeat (TO) tick();
            exp_mcyc = '0; to_flag_m = 1'b1; to_part_m = 4'(p); rd = ERR;
        end
        tick();
        exp_ack = 1'b1; exp_dat = rd; got = wbs_dat_o;
        end_req();
        tick();
        exp_ack = 1'b0; exp_dat = '0;
    endtask

    logic [31:0] got;

    initial begin
        rst = 1'b1; end_req(); bsel = 4'h0; adr = '0; dat = '0;
        m_ack = '0; m_dat = '0; part_irq = '0;
        exp_ack = 1'b0; exp_dat = '0; exp_mcyc = '0; exp_adr = '0; exp_wdat = '0; exp_we = 1'b0;
        mask_m = 6'h3F; to_flag_m = 1'b0; to_part_m = 4'h0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_adr", m_adr_o, 32'h0);
        chk("rst_dat", m_dat_o, 32'h0);
        rst = 1'b0;
        tick();

        // partition 1 write; stray ack from partition 0 must be ignored
        m_ack[0] = 1'b1;
        part_access(32'h3010_0004, 1'b1, 32'h1234_5678, 3, 32'h0, got);
        m_ack[0] = 1'b0;
        tick();

        part_access(32'h3000_0000, 1'b0, 32'h0, 1, 32'hCAFE_0001, got);
        chk("t2_rdata", got, 32'hCAFE_0001);

        // ack on the last watchdog cycle wins
        part_access(32'h3000_0008, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, got);
        chk("ack_at_timeout", got, 32'h0BAD_F00D);
        local_access(32'h30F0_0004, 1'b0, 32'h0, 4'hF, got);
        chk("status_no_to", got, 32'h0000_0200);

        part_access(32'h3010_0000, 1'b0, 32'h0, -1, 32'h0, got);
        chk("timeout_data", got, 32'hDEAD_BEEF);
        local_access(32'h30F0_0004, 1'b0, 32'h0, 4'hF, got);
        chk("status_to", got, 32'h0000_0211);
        local_access(32'h30F0_0004, 1'b1, 32'h1, 4'hF, got);
        local_access(32'h30F0_0004, 1'b0, 32'h0, 4'hF, got);
        chk("status_w1c", got, 32'h0000_0210);

        local_access(32'h3050_0000, 1'b0, 32'h0, 4'hF, got);
        chk("decode_err", got, 32'hDEAD_BEEF);
        local_access(32'h3020_0000, 1'b1, 32'h0, 4'hF, got);
        local_access(32'h30F0_0000, 1'b0, 32'h0, 4'hF, got);
        chk("mask_reset", got, 32'h0000_003F);

        local_access(32'h30F0_0000, 1'b1, 32'h01, 4'hF, got);
        part_irq = 6'b001001;
        tick();
        chk("irq_mask01", 32'(user_irq), 32'h1);
        local_access(32'h30F0_0000, 1'b1, 32'h00, 4'h0, got);
        local_access(32'h30F0_0000, 1'b0, 32'h0, 4'hF, got);
        chk("mask_nobytes", got, 32'h0000_0001);
        local_access(32'h30F0_0000, 1'b1, 32'h3F, 4'h1, got);
        tick();
        chk("irq_mask3f", 32'(user_irq), 32'h1);
        part_irq = 6'b100010;
        tick();
        local_access(32'h30F0_0008, 1'b1, 32'hFFFF_FFFF, 4'hF, got);
        local_access(32'h30F0_0008, 1'b0, 32'h0, 4'hF, got);
        chk("offset2", got, 32'h0);
        local_access(32'h30F0_0000, 1'b1, 32'h05, 4'hF, got);
        part_irq = 6'b111111;
        tick();

        // upstream abort mid-BUSY
        start_req(32'h3000_0010, 1'b0, 32'h0, 4'hF);
        tick();
        exp_mcyc = 2'b01; exp_adr = 32'h3000_0010; exp_wdat = 32'h0; exp_we = 1'b0;
        tick(); tick();
        end_req();
        tick();
        exp_mcyc = '0;
        repeat (3) tick();

        // reset mid-BUSY
        start_req(32'h3010_0000, 1'b1, 32'hA5A5_5A5A, 4'hF);
        tick();
        exp_mcyc = 2'b10; exp_adr = 32'h3010_0000; exp_wdat = 32'hA5A5_5A5A; exp_we = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        exp_mcyc = '0; mask_m = 6'h3F; to_flag_m = 1'b0; to_part_m = 4'h0;
        chk("rst_mid_adr", m_adr_o, 32'h0);
        chk("rst_mid_we", 32'(m_we_o), 32'h0);
        end_req();
        rst = 1'b0;
        tick();
        part_access(32'h3010_0000, 1'b0, 32'h0, 2, 32'h7777_0002, got);
        chk("post_rst_read", got, 32'h7777_0002);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
